// File: rtl/pmem_arbiter.sv
// pmem_arbiter
//   Two-client arbiter that places the I-side and D-side L1 caches onto a
//   single physical-memory port. The request of the granted client is
//   latched on the grant edge and held on the pmem bus until pmem_resp. The
//   response is then returned to that client only.
//
// Handshake: each client holds read or write high as a level until it sees a
//   one-cycle x_resp pulse. Memory completes with a one-cycle pmem_resp. A
//   pmem_resp that arrives while no client is granted is ignored.
//
// Parameters
//   DPRIO  1: the D-side wins every conflict. 0: round-robin, and the last
//          loser wins the next conflict.
//   AW     address width
//   LW     line width
//
// Ports
//   clk, reset_n                         clock, async active-low reset
//   i_read/i_write/i_address/i_wdata     I-side request
//   i_rdata/i_resp                       I-side response
//   d_read/d_write/d_address/d_wdata     D-side request
//   d_rdata/d_resp                       D-side response
//   pmem_read/pmem_write/pmem_address/pmem_wdata   memory request
//   pmem_rdata/pmem_resp                 memory response
//   state_dbg                            FSM state (0 IDLE, 1 GNT_I, 2 GNT_D)
//
// Optional feature: macro ARB_PERF_CNT_EN adds the saturating 16-bit counters
//   perf_i_grants, perf_d_grants and perf_conflicts.
module pmem_arbiter #(
  parameter bit DPRIO = 1'b1,
  parameter int AW    = 16,
  parameter int LW    = 128
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          i_read,
  input  logic          i_write,
  input  logic [AW-1:0] i_address,
  input  logic [LW-1:0] i_wdata,
  output logic [LW-1:0] i_rdata,
  output logic          i_resp,
  input  logic          d_read,
  input  logic          d_write,
  input  logic [AW-1:0] d_address,
  input  logic [LW-1:0] d_wdata,
  output logic [LW-1:0] d_rdata,
  output logic          d_resp,
  output logic          pmem_read,
  output logic          pmem_write,
  output logic [AW-1:0] pmem_address,
  output logic [LW-1:0] pmem_wdata,
  input  logic [LW-1:0] pmem_rdata,
  input  logic          pmem_resp,
  output logic [1:0]    state_dbg
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [15:0]   perf_i_grants,
  output logic [15:0]   perf_d_grants,
  output logic [15:0]   perf_conflicts
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          last_d_q, last_d_d;   // 1: the last completed grant was D
  logic [AW-1:0] addr_q, addr_d;
  logic [LW-1:0] wdata_q, wdata_d;
  logic          op_wr_q, op_wr_d;     // latched op, 1 = write

  logic i_req, d_req, conflict;

  assign i_req    = i_read | i_write;
  assign d_req    = d_read | d_write;
  assign conflict = i_req & d_req;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      last_d_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      op_wr_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_d_q <= last_d_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      op_wr_q  <= op_wr_d;
    end
  end

  // Next-state logic and request latching
  always_comb begin
    state_d  = state_q;
    last_d_d = last_d_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    op_wr_d  = op_wr_q;
    case (state_q)
      IDLE: begin
        if (conflict) begin
          // On a conflict D wins when it has fixed priority, or when I
          // received the last grant (round-robin).
          state_d = (DPRIO || !last_d_q) ? GNT_D : GNT_I;
        end else if (i_req) begin
          state_d = GNT_I;
        end else if (d_req) begin
          state_d = GNT_D;
        end
        // read & write together is illegal; write takes precedence.
        if (state_d == GNT_I) begin
          addr_d  = i_address;
          wdata_d = i_wdata;
          op_wr_d = i_write;
        end else if (state_d == GNT_D) begin
          addr_d  = d_address;
          wdata_d = d_wdata;
          op_wr_d = d_write;
        end
      end
      GNT_I: begin
        if (pmem_resp) begin
          state_d  = IDLE;
          last_d_d = 1'b0;
        end
      end
      GNT_D: begin
        if (pmem_resp) begin
          state_d  = IDLE;
          last_d_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic. The pmem bus carries only latched values, and it is
  // zeroed outside a grant so that every output is 0 while reset is held.
  logic gnt_i, gnt_d, gnt_any;

  always_comb begin
    gnt_i        = (state_q == GNT_I);
    gnt_d        = (state_q == GNT_D);
    gnt_any      = gnt_i | gnt_d;
    pmem_read    = gnt_any & ~op_wr_q;
    pmem_write   = gnt_any & op_wr_q;
    pmem_address = gnt_any ? addr_q : '0;
    pmem_wdata   = gnt_any ? wdata_q : '0;
    i_resp       = gnt_i & pmem_resp;
    d_resp       = gnt_d & pmem_resp;
    i_rdata      = i_resp ? pmem_rdata : '0;
    d_rdata      = d_resp ? pmem_rdata : '0;
    state_dbg    = state_q;
  end

`ifdef ARB_PERF_CNT_EN
  logic [15:0] perf_i_q, perf_i_d;
  logic [15:0] perf_d_q, perf_d_d;
  logic [15:0] perf_c_q, perf_c_d;

  always_comb begin
    perf_i_d = perf_i_q;
    perf_d_d = perf_d_q;
    perf_c_d = perf_c_q;
    if (state_q == IDLE && state_d == GNT_I && perf_i_q != 16'hFFFF)
      perf_i_d = perf_i_q + 16'd1;
    if (state_q == IDLE && state_d == GNT_D && perf_d_q != 16'hFFFF)
      perf_d_d = perf_d_q + 16'd1;
    if (state_q == IDLE && conflict && perf_c_q != 16'hFFFF)
      perf_c_d = perf_c_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_i_q <= '0;
      perf_d_q <= '0;
      perf_c_q <= '0;
    end else begin
      perf_i_q <= perf_i_d;
      perf_d_q <= perf_d_d;
      perf_c_q <= perf_c_d;
    end
  end

  assign perf_i_grants  = perf_i_q;
  assign perf_d_grants  = perf_d_q;
  assign perf_conflicts = perf_c_q;
`endif

`ifndef SYNTHESIS
  // Catch a client that drives read and write together when it is granted.
  always @(posedge clk) begin
    if (reset_n && state_q == IDLE) begin
      assert (!((state_d == GNT_I) && i_read && i_write))
        else $error("pmem_arbiter: I-side read and write both high");
      assert (!((state_d == GNT_D) && d_read && d_write))
        else $error("pmem_arbiter: D-side read and write both high");
    end
  end
`endif

endmodule

// File: tb/tb_pmem_arbiter.sv
// Directed testbench for pmem_arbiter. It contains two instances: u_a with
// DPRIO=1 and u_b with DPRIO=0. Both instances share the same stimulus. The
// bench acts as the memory model and drives pmem_resp and pmem_rdata by hand.
module tb_pmem_arbiter;

  localparam int AW = 16;
  localparam int LW = 128;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          i_read, i_write, d_read, d_write;
  logic [AW-1:0] i_address, d_address;
  logic [LW-1:0] i_wdata, d_wdata, pmem_rdata;
  logic          pmem_resp;

  logic [LW-1:0] a_i_rdata, a_d_rdata, a_pmem_wdata;
  logic          a_i_resp, a_d_resp, a_pmem_read, a_pmem_write;
  logic [AW-1:0] a_pmem_address;
  logic [1:0]    a_state;
  logic [LW-1:0] b_i_rdata, b_d_rdata, b_pmem_wdata;
  logic          b_i_resp, b_d_resp, b_pmem_read, b_pmem_write;
  logic [AW-1:0] b_pmem_address;
  logic [1:0]    b_state;
`ifdef ARB_PERF_CNT_EN
  logic [15:0]   a_pi, a_pd, a_pc, b_pi, b_pd, b_pc;
`endif

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [LW-1:0] LINE_A5 = {16{8'hA5}};
  localparam logic [LW-1:0] LINE_3C = {16{8'h3C}};

  // clock / reset
  always #5 clk = ~clk;

  pmem_arbiter #(.DPRIO(1'b1), .AW(AW), .LW(LW)) u_a (
    .clk(clk), .reset_n(reset_n),
    .i_read(i_read), .i_write(i_write), .i_address(i_address), .i_wdata(i_wdata),
    .i_rdata(a_i_rdata), .i_resp(a_i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(a_d_rdata), .d_resp(a_d_resp),
    .pmem_read(a_pmem_read), .pmem_write(a_pmem_write), .pmem_address(a_pmem_address),
    .pmem_wdata(a_pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
    .state_dbg(a_state)
`ifdef ARB_PERF_CNT_EN
    , .perf_i_grants(a_pi), .perf_d_grants(a_pd), .perf_conflicts(a_pc)
`endif
  );

  pmem_arbiter #(.DPRIO(1'b0), .AW(AW), .LW(LW)) u_b (
    .clk(clk), .reset_n(reset_n),
    .i_read(i_read), .i_write(i_write), .i_address(i_address), .i_wdata(i_wdata),
    .i_rdata(b_i_rdata), .i_resp(b_i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(b_d_rdata), .d_resp(b_d_resp),
    .pmem_read(b_pmem_read), .pmem_write(b_pmem_write), .pmem_address(b_pmem_address),
    .pmem_wdata(b_pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
    .state_dbg(b_state)
`ifdef ARB_PERF_CNT_EN
    , .perf_i_grants(b_pi), .perf_d_grants(b_pd), .perf_conflicts(b_pc)
`endif
  );

  // driver tasks: every step lands 2 time units after a rising edge
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    n_cmp++;
    assert (obs === exp)
      else begin
        n_err++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  // Pulse pmem_resp for one cycle. Completion outputs are checked in the
  // middle of the pulse.
  task automatic resp_on(input logic [LW-1:0] rd);
    pmem_resp  = 1'b1;
    pmem_rdata = rd;
    #1;
  endtask

  task automatic resp_off();
    tick();
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
  endtask

  initial begin
    reset_n = 1'b0;
    i_read = 0; i_write = 0; d_read = 0; d_write = 0;
    i_address = '0; d_address = '0; i_wdata = '0; d_wdata = '0;
    pmem_rdata = '0; pmem_resp = 1'b0;

    // reset state
    #3;
    chk("rst_state", 128'(a_state), 128'd0);
    chk("rst_pread", 128'(a_pmem_read), 128'd0);
    chk("rst_pwrite", 128'(a_pmem_write), 128'd0);
    chk("rst_paddr", 128'(a_pmem_address), 128'd0);
    tick();
    reset_n = 1'b1;

    // single I read @0x1230
    tick();
    i_read = 1'b1; i_address = 16'h1230;
    tick();
    chk("t1_state", 128'(a_state), 128'd1);
    chk("t1_pread", 128'(a_pmem_read), 128'd1);
    chk("t1_pwrite", 128'(a_pmem_write), 128'd0);
    chk("t1_paddr", 128'(a_pmem_address), 128'h1230);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t1_wait_iresp", 128'(a_i_resp), 128'd0);
      chk("t1_wait_pread", 128'(a_pmem_read), 128'd1);
    end
    tick();
    resp_on(LINE_A5);
    chk("t1_iresp", 128'(a_i_resp), 128'd1);
    chk("t1_irdata", a_i_rdata, LINE_A5);
    chk("t1_dresp", 128'(a_d_resp), 128'd0);
    chk("t1_drdata", a_d_rdata, 128'd0);
    i_read = 1'b0;
    resp_off();
    chk("t1_idle", 128'(a_state), 128'd0);
    chk("t1_idle_pread", 128'(a_pmem_read), 128'd0);

    // pmem_resp while idle produces no client response
    resp_on(LINE_3C);
    chk("idle_resp_i", 128'(a_i_resp), 128'd0);
    chk("idle_resp_d", 128'(a_d_resp), 128'd0);
    chk("idle_resp_irdata", a_i_rdata, 128'd0);
    resp_off();
    chk("idle_resp_state", 128'(a_state), 128'd0);

    // conflict, DPRIO=1: D write is served first, then I read, with a bubble
    i_read = 1'b1; i_address = 16'h0100;
    d_write = 1'b1; d_address = 16'h0200; d_wdata = 128'h1;
    tick();
    chk("c1_state_d", 128'(a_state), 128'd2);
    chk("c1_pwrite", 128'(a_pmem_write), 128'd1);
    chk("c1_pread", 128'(a_pmem_read), 128'd0);
    chk("c1_paddr", 128'(a_pmem_address), 128'h0200);
    chk("c1_pwdata", a_pmem_wdata, 128'h1);
    // A change to the live request must not reach the bus.
    d_address = 16'h0300; d_wdata = 128'h7;
    tick();
    chk("stab_paddr", 128'(a_pmem_address), 128'h0200);
    chk("stab_pwdata", a_pmem_wdata, 128'h1);
    tick();
    chk("stab_paddr2", 128'(a_pmem_address), 128'h0200);
    resp_on('0);
    chk("c1_dresp", 128'(a_d_resp), 128'd1);
    chk("c1_iresp", 128'(a_i_resp), 128'd0);
    d_write = 1'b0;
    resp_off();
    chk("c1_bubble", 128'(a_state), 128'd0);
    chk("c1_bubble_pread", 128'(a_pmem_read), 128'd0);
    chk("c1_bubble_pwrite", 128'(a_pmem_write), 128'd0);
    tick();
    chk("c1_state_i", 128'(a_state), 128'd1);
    chk("c1_i_pread", 128'(a_pmem_read), 128'd1);
    chk("c1_i_paddr", 128'(a_pmem_address), 128'h0100);
    resp_on(LINE_3C);
    chk("c1_i_iresp", 128'(a_i_resp), 128'd1);
    chk("c1_i_irdata", a_i_rdata, LINE_3C);
    chk("c1_i_drdata", a_d_rdata, 128'd0);
    i_read = 1'b0;
    resp_off();

    // reset during GNT_I, released with d_read held
    i_read = 1'b1; i_address = 16'h0400;
    tick();
    chk("rm_state_pre", 128'(a_state), 128'd1);
    d_read = 1'b1; d_address = 16'h0500;
    reset_n = 1'b0;
    #1;
    chk("rm_state", 128'(a_state), 128'd0);
    chk("rm_pread", 128'(a_pmem_read), 128'd0);
    chk("rm_paddr", 128'(a_pmem_address), 128'd0);
    chk("rm_iresp", 128'(a_i_resp), 128'd0);
    tick();
    i_read = 1'b0;
    reset_n = 1'b1;
    tick();
    chk("rm_gnt_d", 128'(a_state), 128'd2);
    chk("rm_d_paddr", 128'(a_pmem_address), 128'h0500);
    chk("rm_d_pread", 128'(a_pmem_read), 128'd1);
    resp_on(LINE_A5);
    chk("rm_dresp", 128'(a_d_resp), 128'd1);
    chk("rm_no_iresp", 128'(a_i_resp), 128'd0);
    d_read = 1'b0;
    resp_off();

    // DPRIO=0 round-robin (u_b). A solo D read first makes last_grant = D,
    // so continuous conflicts must then go I, D, I, D.
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    d_read = 1'b1; d_address = 16'h0700;
    tick();
    chk("rr_solo_d", 128'(b_state), 128'd2);
    resp_on('0);
    chk("rr_solo_dresp", 128'(b_d_resp), 128'd1);
    resp_off();
    i_read = 1'b1; i_address = 16'h0800;
    d_read = 1'b1; d_address = 16'h0900;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (k % 2 == 0) begin
        chk("rr_gnt_i", 128'(b_state), 128'd1);
        chk("rr_paddr_i", 128'(b_pmem_address), 128'h0800);
        resp_on(LINE_A5);
        chk("rr_iresp", 128'(b_i_resp), 128'd1);
        chk("rr_irdata", b_i_rdata, LINE_A5);
        chk("rr_no_dresp", 128'(b_d_resp), 128'd0);
      end else begin
        chk("rr_gnt_d", 128'(b_state), 128'd2);
        chk("rr_paddr_d", 128'(b_pmem_address), 128'h0900);
        resp_on(LINE_3C);
        chk("rr_dresp", 128'(b_d_resp), 128'd1);
        chk("rr_drdata", b_d_rdata, LINE_3C);
        chk("rr_no_iresp", 128'(b_i_resp), 128'd0);
      end
      resp_off();
      chk("rr_bubble", 128'(b_state), 128'd0);
    end
    i_read = 1'b0; d_read = 1'b0;

`ifdef ARB_PERF_CNT_EN
    // 3 conflicts and then 2 solo I reads on u_a
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("perf_rst", 128'(a_pc), 128'd0);
    for (int c = 0; c < 3; c++) begin
      i_read = 1'b1; d_read = 1'b1;
      tick();
      resp_on('0);
      d_read = 1'b0;
      resp_off();
      tick();
      resp_on('0);
      i_read = 1'b0;
      resp_off();
    end
    for (int s = 0; s < 2; s++) begin
      i_read = 1'b1;
      tick();
      resp_on('0);
      i_read = 1'b0;
      resp_off();
    end
    tick();
    chk("perf_conflicts", 128'(a_pc), 128'd3);
    chk("perf_i_grants", 128'(a_pi), 128'd5);
    chk("perf_d_grants", 128'(a_pd), 128'd3);
`endif

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
